// File: rtl/seven_segment_mux.sv
// Time-multiplexed hex driver for a DIGITS-wide common seven-segment display.
// Define SEVEN_SEGMENT_LZ_BLANK_EN to suppress leading-zero digits (digit 0 always shown).
module seven_segment_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank,
  output logic                  seg_a,
  output logic                  seg_b,
  output logic                  seg_c,
  output logic                  seg_d,
  output logic                  seg_e,
  output logic                  seg_f,
  output logic                  seg_g,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [PCNT_W-1:0] GUARD_V  = PCNT_W'(GUARD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] abcdefg;
    case (nib)
      4'h0:    abcdefg = 7'b1111110;
      4'h1:    abcdefg = 7'b0110000;
      4'h2:    abcdefg = 7'b1101101;
      4'h3:    abcdefg = 7'b1111001;
      4'h4:    abcdefg = 7'b0110011;
      4'h5:    abcdefg = 7'b1011011;
      4'h6:    abcdefg = 7'b1011111;
      4'h7:    abcdefg = 7'b1110000;
      4'h8:    abcdefg = 7'b1111111;
      4'h9:    abcdefg = 7'b1111011;
      4'hA:    abcdefg = 7'b1110111;
      4'hB:    abcdefg = 7'b0011111;
      4'hC:    abcdefg = 7'b1001110;
      4'hD:    abcdefg = 7'b0111101;
      4'hE:    abcdefg = 7'b1001111;
      default: abcdefg = 7'b1000111;
    endcase
    return abcdefg;
  endfunction

  logic [PCNT_W-1:0]   pcnt, pcnt_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic                tick, wrap;
  logic [4*DIGITS-1:0] shadow;
  logic                armed;
  logic [6:0]          seg_q, seg_next;
  logic [3:0]          nibble;
  logic                suppress;
  logic [DIGITS-1:0]   en_next;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    tick      = (pcnt == PCNT_MAX);
    wrap      = tick && (idx == LAST_IDX);
    pcnt_next = tick ? '0 : pcnt + PCNT_W'(1);
    idx_next  = idx;
    if (wrap)      idx_next = '0;
    else if (tick) idx_next = idx + IDX_W'(1);
  end

  // Select the shadow nibble for the digit about to be scanned.
  always_comb begin
    nibble   = '0;
    suppress = 1'b0;
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        upper_zero = upper_zero && (shadow[4*i +: 4] == 4'h0);
        if (idx_next == IDX_W'(i)) begin
          nibble   = shadow[4*i +: 4];
          suppress = upper_zero && (i != 0);
        end
      end
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) nibble = shadow[4*i +: 4];
    end
`endif
    seg_next = suppress ? 7'b0000000 : decode_hex(nibble);
  end

  // Enables stay dark until the first tick after reset, during the guard window and while blanked.
  always_comb begin
    en_next = '0;
    if (!blank && (armed || tick) && !(pcnt_next < GUARD_V))
      en_next = DIGITS'(1) << idx_next;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      shadow     <= '0;
      armed      <= 1'b0;
      seg_q      <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= pcnt_next;
      idx        <= idx_next;
      frame_done <= wrap;
      digit_en   <= en_next;
      if (load) shadow <= value;
      if (tick) begin
        seg_q <= seg_next;
        armed <= 1'b1;
      end
    end
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: a per-edge vector table for one full scan,
// then hand-written sequences for blanking, load/tick collision, leading zeros and mid-guard reset.
module tb_seven_segment_mux;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int GUARD       = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_pass   = 0;

  assign seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  seven_segment_mux #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank(blank),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  en;
    logic [6:0]  sg;
    logic        fd;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    load  = 1'b0;
    blank = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b1110000, S8 = 7'b1111111, SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111, SX = 7'b0000000;

  initial begin
    // Edge-by-edge expectations after reset release with 16'h12AF loaded at edge 1.
    vecs[0]  = '{1'b1, 16'h12AF, 4'b0000, SX, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 4'b0000, SX, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 4'b0000, SX, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 4'b0000, SA, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 4'b0010, SA, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 4'b0010, SA, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 4'b0010, SA, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 4'b0000, S2, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 4'b0100, S2, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 4'b0100, S2, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 4'b0100, S2, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 4'b0000, S1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 4'b1000, S1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 4'b1000, S1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 4'b1000, S1, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 4'b0000, SF, 1'b1};
    vecs[16] = '{1'b0, 16'h0000, 4'b0001, SF, 1'b0};
    vecs[17] = '{1'b0, 16'h0000, 4'b0001, SF, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 4'b0001, SF, 1'b0};
    vecs[19] = '{1'b0, 16'h0000, 4'b0000, SA, 1'b0};

    // Reset overrides a simultaneous load.
    rst   = 1'b1;
    load  = 1'b1;
    blank = 1'b0;
    value = 16'hFFFF;
    step();
    step();
    check("reset digit_en", 32'(digit_en), 32'h0);
    check("reset seg", 32'(seg), 32'h0);
    check("reset frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      load  = vecs[i].ld;
      value = vecs[i].val;
      step();
      check($sformatf("scan edge%0d digit_en", i + 1), 32'(digit_en), 32'(vecs[i].en));
      check($sformatf("scan edge%0d seg", i + 1), 32'(seg), 32'(vecs[i].sg));
      check($sformatf("scan edge%0d frame_done", i + 1), 32'(frame_done), 32'(vecs[i].fd));
    end
    load = 1'b0;

    // Free run with blank held over edges 6..11: frame_done stays on a 16-edge period.
    do_reset();
    load  = 1'b1;
    value = 16'h12AF;
    step();
    load = 1'b0;
    check("blank edge1 frame_done", 32'(frame_done), 32'h0);
    for (int k = 2; k <= 48; k++) begin
      blank = (k >= 6 && k <= 11);
      step();
      check($sformatf("run edge%0d frame_done", k), 32'(frame_done), 32'((k % 16) == 0));
      if (k >= 6 && k <= 11)
        check($sformatf("blank edge%0d digit_en", k), 32'(digit_en), 32'h0);
      if (k == 12) begin
        check("after blank idx3 seg", 32'(seg), 32'(S1));
        check("after blank guard digit_en", 32'(digit_en), 32'h0);
      end
      if (k == 13)
        check("after blank resume digit_en", 32'(digit_en), 32'(4'b1000));
    end
    blank = 1'b0;

    // Load 16'h8888 on the tick edge: scanned digit still uses the old shadow.
    do_reset();
    step();
    step();
    step();
    load  = 1'b1;
    value = 16'h8888;
    step();
    load = 1'b0;
    check("collide tick seg", 32'(seg), 32'(S0));
    check("collide tick digit_en", 32'(digit_en), 32'h0);
    step();
    check("collide digit1 digit_en", 32'(digit_en), 32'(4'b0010));
    step();
    step();
    step();
    check("collide next digit seg", 32'(seg), 32'(S8));

    // Leading-zero handling for 16'h0070.
    do_reset();
    load  = 1'b1;
    value = 16'h0070;
    step();
    load = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      if (k == 4) check("lz digit1 seg", 32'(seg), 32'(S7));
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
      if (k == 8)  check("lz digit2 seg", 32'(seg), 32'(SX));
      if (k == 12) check("lz digit3 seg", 32'(seg), 32'(SX));
`else
      if (k == 8)  check("lz digit2 seg", 32'(seg), 32'(S0));
      if (k == 12) check("lz digit3 seg", 32'(seg), 32'(S0));
`endif
      if (k == 16) check("lz digit0 seg", 32'(seg), 32'(S0));
    end

    // Reset during the guard cycle of digit 2, then a clean restart with a cleared shadow.
    do_reset();
    load  = 1'b1;
    value = 16'h12AF;
    step();
    load = 1'b0;
    for (int k = 2; k <= 8; k++) step();
    check("guard2 digit_en", 32'(digit_en), 32'h0);
    check("guard2 seg", 32'(seg), 32'(S2));
    rst = 1'b1;
    step();
    check("midreset digit_en", 32'(digit_en), 32'h0);
    check("midreset seg", 32'(seg), 32'h0);
    check("midreset frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("restart edge%0d digit_en", k), 32'(digit_en), 32'h0);
    end
    step();
    check("restart tick seg", 32'(seg), 32'(S0));
    check("restart tick digit_en", 32'(digit_en), 32'h0);
    step();
    check("restart digit1 digit_en", 32'(digit_en), 32'(4'b0010));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
